// File: rtl/frost32_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// PkgFrost32IrqCtrl : shared types and width helpers for the Frost32 IRQ ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package PkgFrost32IrqCtrl;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAssert  = 2'd1,
    StHoldoff = 2'd2
  } state_e;

  // Counters need at least one bit even when the parameter is 0 or 1.
  function automatic int clog2_min2(input int value);
    return (value < 2) ? 1 : $clog2(value);
  endfunction

  localparam int DEF_NUM_SOURCES    = 8;
  localparam int DEF_PULSE_CYCLES   = 4;
  localparam int DEF_HOLDOFF_CYCLES = 16;
  localparam int DEF_CAUSE_W        = $clog2(DEF_NUM_SOURCES);
  localparam int DEF_PULSE_CNT_W    = clog2_min2(DEF_PULSE_CYCLES);
  localparam int DEF_HOLD_CNT_W     = clog2_min2(DEF_HOLDOFF_CYCLES);

  typedef struct packed {
    logic [DEF_NUM_SOURCES-1:0] irq_src;
    logic                       mask_wr_en;
    logic [DEF_NUM_SOURCES-1:0] mask_wr_data;
    logic                       wait_for_mem;
  } PortIn_Frost32IrqCtrl;

  typedef struct packed {
    logic                       interrupt;
    logic [DEF_CAUSE_W-1:0]     irq_cause;
    logic [DEF_NUM_SOURCES-1:0] pending;
    logic [DEF_NUM_SOURCES-1:0] mask;
  } PortOut_Frost32IrqCtrl;

endpackage

`default_nettype wire

// File: rtl/frost32_irq_ctrl_prio_enc.sv
// ---------------------------------------------------------------------------
// frost32_irq_prio_enc : combinational lowest-index-first priority encoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frost32_irq_prio_enc #(
  parameter int NUM_SOURCES = 8
) (
  input  logic [NUM_SOURCES-1:0]         eligible_i,
  output logic                           valid_o,
  output logic [$clog2(NUM_SOURCES)-1:0] index_o,
  output logic [NUM_SOURCES-1:0]         onehot_o
);

  localparam int CAUSE_W = $clog2(NUM_SOURCES);

  always_comb begin
    valid_o  = |eligible_i;
    // Isolate the lowest set bit.
    onehot_o = eligible_i & (~eligible_i + 1'b1);
    index_o  = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        index_o = CAUSE_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/frost32_irq_ctrl.sv
// ---------------------------------------------------------------------------
// frost32_irq_ctrl : edge-latched, masked, prioritised interrupt pulser
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frost32_irq_ctrl
  import PkgFrost32IrqCtrl::*;
#(
  parameter int NUM_SOURCES    = 8,
  parameter int PULSE_CYCLES   = 4,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SOURCES-1:0]         irq_src,
  input  logic                           mask_wr_en,
  input  logic [NUM_SOURCES-1:0]         mask_wr_data,
  input  logic                           wait_for_mem,
  output logic                           interrupt,
  output logic [$clog2(NUM_SOURCES)-1:0] irq_cause,
  output logic [NUM_SOURCES-1:0]         pending,
  output logic [NUM_SOURCES-1:0]         mask
);

  localparam int CAUSE_W = $clog2(NUM_SOURCES);
  localparam int PCNT_W  = clog2_min2(PULSE_CYCLES);
  localparam int HCNT_W  = clog2_min2(HOLDOFF_CYCLES);
  localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HOLD_LOAD  =
      HCNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  state_e                 state_q, state_d;
  logic                   interrupt_q, interrupt_d;
  logic [CAUSE_W-1:0]     cause_q, cause_d;
  logic [PCNT_W-1:0]      pcnt_q, pcnt_d;
  logic [HCNT_W-1:0]      hcnt_q, hcnt_d;
  logic [NUM_SOURCES-1:0] prev_q, pending_q, pending_d, mask_q, mask_d;
  logic [NUM_SOURCES-1:0] edge_det, eligible, win_onehot, clr;
  logic [CAUSE_W-1:0]     win_index;
  logic                   win_valid;

  assign edge_det = irq_src & ~prev_q;
  assign eligible = pending_q & mask_q;

  frost32_irq_prio_enc #(
    .NUM_SOURCES (NUM_SOURCES)
  ) u_prio_enc (
    .eligible_i (eligible),
    .valid_o    (win_valid),
    .index_o    (win_index),
    .onehot_o   (win_onehot)
  );

  always_comb begin
    state_d     = state_q;
    interrupt_d = interrupt_q;
    cause_d     = cause_q;
    pcnt_d      = pcnt_q;
    hcnt_d      = hcnt_q;
    clr         = '0;
    unique case (state_q)
      StIdle: begin
        interrupt_d = 1'b0;
        if (win_valid && !wait_for_mem) begin
          state_d     = StAssert;
          interrupt_d = 1'b1;
          cause_d     = win_index;
          clr         = win_onehot;
          pcnt_d      = PULSE_LOAD;
        end
      end
      StAssert: begin
        if (!wait_for_mem) begin
          if (pcnt_q == '0) begin
            interrupt_d = 1'b0;
            hcnt_d      = HOLD_LOAD;
            state_d     = (HOLDOFF_CYCLES == 0) ? StIdle : StHoldoff;
          end else begin
            pcnt_d = pcnt_q - 1'b1;
          end
        end
      end
      StHoldoff: begin
        interrupt_d = 1'b0;
        if (hcnt_q == '0) begin
          state_d = StIdle;
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        interrupt_d = 1'b0;
      end
    endcase
  end

  // Set after clear so a fresh edge on the launching source is not lost.
  assign pending_d = (pending_q & ~clr) | edge_det;
  assign mask_d    = mask_wr_en ? mask_wr_data : mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      interrupt_q <= 1'b0;
      cause_q     <= '0;
      pcnt_q      <= '0;
      hcnt_q      <= '0;
      prev_q      <= '0;
      pending_q   <= '0;
      mask_q      <= '1;
    end else begin
      state_q     <= state_d;
      interrupt_q <= interrupt_d;
      cause_q     <= cause_d;
      pcnt_q      <= pcnt_d;
      hcnt_q      <= hcnt_d;
      prev_q      <= irq_src;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
    end
  end

  assign interrupt = interrupt_q;
  assign irq_cause = cause_q;
  assign pending   = pending_q;
  assign mask      = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_frost32_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frost32_irq_ctrl : directed self-checking bench for frost32_irq_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_frost32_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_src;
  logic       mask_wr_en;
  logic [7:0] mask_wr_data;
  logic       wait_for_mem;
  logic       interrupt;
  logic [2:0] irq_cause;
  logic [7:0] pending;
  logic [7:0] mask;

  int errors = 0;
  int checks = 0;

  frost32_irq_ctrl #(
    .NUM_SOURCES    (8),
    .PULSE_CYCLES   (4),
    .HOLDOFF_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_src      (irq_src),
    .mask_wr_en   (mask_wr_en),
    .mask_wr_data (mask_wr_data),
    .wait_for_mem (wait_for_mem),
    .interrupt    (interrupt),
    .irq_cause    (irq_cause),
    .pending      (pending),
    .mask         (mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    logic last_int;

    rst          = 1'b1;
    irq_src      = 8'h00;
    mask_wr_en   = 1'b0;
    mask_wr_data = 8'h00;
    wait_for_mem = 1'b0;
    tick();
    tick();
    check("rst_int",     32'(interrupt), 32'h0);
    check("rst_cause",   32'(irq_cause), 32'h0);
    check("rst_pending", 32'(pending),   32'h00);
    check("rst_mask",    32'(mask),      32'hFF);
    rst = 1'b0;
    tick();

    // Single request on source 3
    irq_src = 8'h08;
    tick();
    check("t1_pend_set", 32'(pending),   32'h08);
    check("t1_no_int",   32'(interrupt), 32'h0);
    tick();
    check("t1_int_on",   32'(interrupt), 32'h1);
    check("t1_cause",    32'(irq_cause), 32'h3);
    check("t1_pend_clr", 32'(pending),   32'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_int_hold", 32'(interrupt), 32'h1);
    end
    tick();
    check("t1_int_off",  32'(interrupt), 32'h0);
    check("t1_cause_hold", 32'(irq_cause), 32'h3);
    irq_src = 8'h00;
    repeat (20) tick();

    // Priority and holdoff: sources 5 and 2 together
    irq_src = 8'h24;
    tick();
    check("t2_pend", 32'(pending), 32'h24);
    tick();
    check("t2_int_on",  32'(interrupt), 32'h1);
    check("t2_cause2",  32'(irq_cause), 32'h2);
    check("t2_pend5",   32'(pending),   32'h20);
    repeat (3) tick();
    check("t2_int_last", 32'(interrupt), 32'h1);
    tick();
    check("t2_int_off",  32'(interrupt), 32'h0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t2_gap_low", 32'(interrupt), 32'h0);
    end
    check("t2_pend_gap", 32'(pending), 32'h20);
    tick();
    check("t2_int2_on", 32'(interrupt), 32'h1);
    check("t2_cause5",  32'(irq_cause), 32'h5);
    check("t2_pend0",   32'(pending),   32'h00);
    repeat (4) tick();
    check("t2_int2_off", 32'(interrupt), 32'h0);
    irq_src = 8'h00;
    repeat (20) tick();

    // Stall gating on source 4
    wait_for_mem = 1'b1;
    irq_src      = 8'h10;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t3_stall_low", 32'(interrupt), 32'h0);
    end
    check("t3_pend", 32'(pending), 32'h10);
    wait_for_mem = 1'b0;
    tick();
    check("t3_int_on", 32'(interrupt), 32'h1);
    check("t3_cause",  32'(irq_cause), 32'h4);
    tick();
    check("t3_hi2", 32'(interrupt), 32'h1);
    wait_for_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_frozen_hi", 32'(interrupt), 32'h1);
    end
    wait_for_mem = 1'b0;
    tick();
    check("t3_hi6", 32'(interrupt), 32'h1);
    tick();
    check("t3_hi7", 32'(interrupt), 32'h1);
    tick();
    check("t3_off", 32'(interrupt), 32'h0);
    irq_src = 8'h00;
    repeat (20) tick();

    // Mask gating on source 0
    mask_wr_en   = 1'b1;
    mask_wr_data = 8'h00;
    tick();
    mask_wr_en = 1'b0;
    check("t4_mask0", 32'(mask), 32'h00);
    irq_src = 8'h01;
    tick();
    check("t4_pend", 32'(pending), 32'h01);
    tick();
    tick();
    check("t4_masked_low", 32'(interrupt), 32'h0);
    check("t4_still_pend", 32'(pending),   32'h01);
    mask_wr_en   = 1'b1;
    mask_wr_data = 8'h01;
    tick();
    mask_wr_en = 1'b0;
    check("t4_mask1",    32'(mask),      32'h01);
    check("t4_wr_low",   32'(interrupt), 32'h0);
    tick();
    check("t4_int_on",   32'(interrupt), 32'h1);
    check("t4_cause0",   32'(irq_cause), 32'h0);
    repeat (4) tick();
    check("t4_int_off",  32'(interrupt), 32'h0);
    irq_src      = 8'h00;
    mask_wr_en   = 1'b1;
    mask_wr_data = 8'hFF;
    tick();
    mask_wr_en = 1'b0;
    repeat (20) tick();

    // Set wins over clear on source 1
    mask_wr_en   = 1'b1;
    mask_wr_data = 8'hFD;
    tick();
    mask_wr_en = 1'b0;
    irq_src    = 8'h02;
    tick();
    irq_src = 8'h00;
    tick();
    check("t5_pend", 32'(pending), 32'h02);
    mask_wr_en   = 1'b1;
    mask_wr_data = 8'hFF;
    tick();
    check("t5_pre_low", 32'(interrupt), 32'h0);
    mask_wr_en = 1'b0;
    irq_src    = 8'h02;
    tick();
    check("t5_int_on",    32'(interrupt), 32'h1);
    check("t5_cause1",    32'(irq_cause), 32'h1);
    check("t5_set_wins",  32'(pending),   32'h02);
    repeat (4) tick();
    check("t5_int_off",   32'(interrupt), 32'h0);
    repeat (16) tick();
    check("t5_gap_low",   32'(interrupt), 32'h0);
    tick();
    check("t5_int2_on",   32'(interrupt), 32'h1);
    check("t5_cause1b",   32'(irq_cause), 32'h1);
    check("t5_pend_clr",  32'(pending),   32'h00);
    repeat (4) tick();
    irq_src = 8'h00;
    repeat (25) tick();

    // Level held high for 100 cycles yields one pulse
    pulses   = 0;
    last_int = interrupt;
    irq_src  = 8'h40;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (interrupt && !last_int) pulses++;
      last_int = interrupt;
    end
    check("t5_level_pulses", 32'(pulses), 32'd1);
    irq_src = 8'h00;
    repeat (25) tick();

    // Reset mid-pulse
    irq_src = 8'h80;
    tick();
    tick();
    check("t6_int_on", 32'(interrupt), 32'h1);
    check("t6_cause7", 32'(irq_cause), 32'h7);
    mask_wr_en   = 1'b1;
    mask_wr_data = 8'h0F;
    irq_src      = 8'h90;
    tick();
    check("t6_mask_wr", 32'(mask),    32'h0F);
    check("t6_pend4",   32'(pending), 32'h10);
    rst        = 1'b1;
    mask_wr_en = 1'b0;
    tick();
    check("t6_rst_int",   32'(interrupt), 32'h0);
    check("t6_rst_pend",  32'(pending),   32'h00);
    check("t6_rst_mask",  32'(mask),      32'hFF);
    check("t6_rst_cause", 32'(irq_cause), 32'h0);
    rst = 1'b0;
    tick();
    check("t6_prev_cleared", 32'(pending), 32'h90);
    tick();
    check("t6_idle_launch", 32'(interrupt), 32'h1);
    check("t6_cause4",      32'(irq_cause), 32'h4);
    check("t6_pend7",       32'(pending),   32'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
